// File: rtl/layer_mixer_n_if.sv
// layer_mixer_n_if: pixel, config and status bundle for the N-layer compositor
// Ports (slave = compositor side):
//   in  i_frame_start, i_data_enable, i_colors, i_active, i_bg_color,
//       i_cfg_wr, i_cfg_layer, i_cfg_mode
//   out o_color, o_data_enable, o_top_layer, o_any_active, o_cfg_pending
interface layer_mixer_n_if #(
    parameter int LAYERS  = 2,
    parameter int COLOR_W = 8,
    parameter int IDX_W   = 3
);
    logic                        i_frame_start;
    logic                        i_data_enable;
    logic [LAYERS*3*COLOR_W-1:0] i_colors;
    logic [LAYERS-1:0]           i_active;
    logic [3*COLOR_W-1:0]        i_bg_color;
    logic                        i_cfg_wr;
    logic [IDX_W-1:0]            i_cfg_layer;
    logic [1:0]                  i_cfg_mode;
    logic [3*COLOR_W-1:0]        o_color;
    logic                        o_data_enable;
    logic [IDX_W-1:0]            o_top_layer;
    logic                        o_any_active;
    logic                        o_cfg_pending;
    modport master (
        output i_frame_start, i_data_enable, i_colors, i_active, i_bg_color,
               i_cfg_wr, i_cfg_layer, i_cfg_mode,
        input  o_color, o_data_enable, o_top_layer, o_any_active, o_cfg_pending
    );
    modport slave (
        input  i_frame_start, i_data_enable, i_colors, i_active, i_bg_color,
               i_cfg_wr, i_cfg_layer, i_cfg_mode,
        output o_color, o_data_enable, o_top_layer, o_any_active, o_cfg_pending
    );
endinterface

// File: rtl/layer_mixer_n.sv
// layer_mixer_n: N-layer RGB compositor with per-layer off/opaque/blend/add modes, frame-synced
// Ports:
//   i_clk, i_rst (sync, active-high)
//   bus (slave): pixel stream in, config writes in, composed pixel and status out
module layer_mixer_n #(
    parameter int LAYERS  = 2,
    parameter int COLOR_W = 8,
    parameter int IDX_W   = 3
) (
    input logic            i_clk,
    input logic            i_rst,
    layer_mixer_n_if.slave bus
);
    localparam int PW = 3 * COLOR_W;

    logic [LAYERS-1:0][1:0]     shadow, live, sh_nxt, mode1;
    logic [LAYERS-1:0]          eff, eff1;
    logic [LAYERS*PW-1:0]       col1;
    logic [PW-1:0]              bg1, acc;
    logic                       de1;
    logic [IDX_W-1:0]           top;
    logic [COLOR_W:0]           sum;
    logic [COLOR_W-1:0]         pix;

    // Shadow after this cycle's write; also what live takes at frame start (write-through).
    always_comb begin
        sh_nxt = shadow;
        for (int k = 0; k < LAYERS; k++)
            if (bus.i_cfg_wr && 32'(bus.i_cfg_layer) == k) sh_nxt[k] = bus.i_cfg_mode;
    end

    always_comb begin
        eff = '0;
        for (int k = 0; k < LAYERS; k++) eff[k] = bus.i_active[k] & |live[k];
    end

    // Bottom-to-top chain; each contributing layer operates on what lies beneath it.
    always_comb begin
        acc = bg1;
        top = '0;
        sum = '0;
        pix = '0;
        for (int k = 0; k < LAYERS; k++)
            if (eff1[k]) begin
                top = IDX_W'(k);
                for (int c = 0; c < 3; c++) begin
                    pix = col1[k*PW + c*COLOR_W +: COLOR_W];
                    sum = {1'b0, acc[c*COLOR_W +: COLOR_W]} + {1'b0, pix};
                    acc[c*COLOR_W +: COLOR_W] = mode1[k] == 2'b01 ? pix :
                                                mode1[k] == 2'b10 ? sum[COLOR_W:1] :
                                                sum[COLOR_W] ? '1 : sum[COLOR_W-1:0];
                end
            end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            shadow             <= {LAYERS{2'b01}};
            live               <= {LAYERS{2'b01}};
            mode1              <= {LAYERS{2'b01}};
            eff1               <= '0;
            col1               <= '0;
            bg1                <= '0;
            de1                <= 1'b0;
            bus.o_color        <= '0;
            bus.o_data_enable  <= 1'b0;
            bus.o_top_layer    <= '0;
            bus.o_any_active   <= 1'b0;
            bus.o_cfg_pending  <= 1'b0;
        end else begin
            shadow             <= sh_nxt;
            if (bus.i_frame_start) live <= sh_nxt;
            mode1              <= live;
            eff1               <= eff;
            col1               <= bus.i_colors;
            bg1                <= bus.i_bg_color;
            de1                <= bus.i_data_enable;
            bus.o_color        <= de1 ? acc : '0;
            bus.o_data_enable  <= de1;
            bus.o_top_layer    <= de1 ? top : '0;
            bus.o_any_active   <= de1 & |eff1;
            bus.o_cfg_pending  <= shadow != live;
        end
    end
endmodule

// File: doc/layer_mixer_n.md
Name: layer_mixer_n

Overview:
Parametrised N-layer video compositor, successor to the fixed two-layer colour mixer between the tile layers and lcd_driver. Combines LAYERS RGB pixel streams over a background colour, highest index on top, and gives each layer a runtime mode: off, opaque, 50 % blend or saturating additive. Mode changes are double-buffered and take effect only at frame start, so the game controller can retarget layers without tearing. Two-stage registered pipeline; data-enable travels alongside the pixel.

Parameters:
LAYERS, 2, number of input layers (2..8); index LAYERS-1 is topmost
COLOR_W, 8, bits per colour channel; pixel = {R,G,B} = 3*COLOR_W bits
IDX_W, 3, width of layer-index fields; must satisfy 2^IDX_W >= LAYERS

Ports:
i_clk  in  1  pixel-domain clock
i_rst  in  1  synchronous reset, active-high
i_frame_start  in  1  one-cycle pulse at start of frame (vertical blank)
i_data_enable  in  1  pixel-valid strobe from timing generator
i_colors  in  LAYERS*3*COLOR_W  layer pixels; layer k at bits [k*3*COLOR_W +: 3*COLOR_W]
i_active  in  LAYERS  per-layer "pixel not transparent" flag
i_bg_color  in  3*COLOR_W  colour shown when no layer contributes
i_cfg_wr  in  1  write strobe for layer mode
i_cfg_layer  in  IDX_W  layer index for write
i_cfg_mode  in  2  00 off, 01 opaque, 10 blend50, 11 additive
o_color  out  3*COLOR_W  composed pixel
o_data_enable  out  1  i_data_enable delayed 2 cycles
o_top_layer  out  IDX_W  index of highest contributing layer (0 if none)
o_any_active  out  1  at least one layer contributed
o_cfg_pending  out  1  shadow modes differ from live modes

Behaviour:
- Reset (i_rst high at a clock edge): shadow and live mode of every layer = 01 (opaque); o_color=0, o_data_enable=0, o_top_layer=0, o_any_active=0, o_cfg_pending=0; both pipeline stages flushed. Reset asserted mid-frame gives zeros on the following cycle.
- Config write: i_cfg_wr=1 with i_cfg_layer<LAYERS loads shadow[i_cfg_layer]=i_cfg_mode. i_cfg_layer>=LAYERS: write ignored.
- Frame sync: i_frame_start=1 copies all shadow modes to live. If i_cfg_wr and i_frame_start are in the same cycle, the write lands in live as well (write-through).
- o_cfg_pending is registered, = (shadow != live) as of the previous edge.
- Stage 1 (cycle n): register i_colors, i_bg_color, i_data_enable and the effective mask eff[k] = i_active[k] & (live[k] != 00). Mask uses live modes at cycle n.
- Stage 2 (cycle n+1): acc = bg; for k = 0..LAYERS-1 where eff[k]=1, per channel:
  - opaque: acc = c
  - blend50: acc = (acc + c) >> 1, computed at COLOR_W+1 bits, truncated (floor)
  - additive: acc = min(acc + c, 2^COLOR_W - 1)
- Register outputs: o_color = acc when delayed DE=1, else 0. o_top_layer = highest k with eff[k]=1, else 0. o_any_active = |eff. Both are also zeroed when DE=0.
- Latency: input at edge n appears at outputs after edge n+2; throughput 1 pixel/cycle, no stalls.
- Stage-2 logic is a combinational chain of LAYERS steps. Layer order is fixed, so blend/add results depend on what is underneath.

Test Plan:
- Reset: hold i_rst 2 cycles with random inputs -> all outputs 0; then LAYERS=2 with both active, colours 0x102030/0xA0B0C0 -> o_color=0xA0B0C0, o_top_layer=1, 2 cycles after DE.
- Blend: cfg layer1=10 + frame_start; bg irrelevant, L0=0x204060 active, L1=0x605040 active -> o_color=0x404850; L0 inactive, bg=0x000000 -> 0x302820.
- Additive saturate: layer1=11, L0=0xF08010, L1=0x20A005 -> 0xFFFF15.
- Frame sync: write layer1=00 mid-frame -> o_cfg_pending=1, output unchanged until frame_start; next pixel after frame_start shows layer0, pending=0. Simultaneous wr+frame_start -> applied at that frame_start.
- Out-of-range: LAYERS=3, IDX_W=2, write index 3 -> no mode change, pending stays 0.
- DE low / none active: DE=0 -> o_color=0, o_any_active=0; DE=1 with i_active=0 -> o_color=i_bg_color, o_top_layer=0, o_any_active=0.
